sseg_anode_scan_capture: RTL and testbench

//  Receive-side monitor for a multiplexed common-anode 7-segment display bus.

---
 rtl/sseg_anode_scan_capture.sv | 200 ++++++++++++++++++++
 tb/tb_sseg_anode_scan_capture.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sseg_anode_scan_capture.sv
// Monitor for a multiplexed common-anode 7-segment bus: waits for each
// digit's pattern to settle, decodes it back to hex + DP and holds it.
module sseg_anode_scan_capture #(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 16
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic [7:0]              SSeg,
  input  logic [NUM_DIGITS-1:0]   Anode,
  output logic [4*NUM_DIGITS-1:0] Digits,
  output logic [NUM_DIGITS-1:0]   DPs,
  output logic [NUM_DIGITS-1:0]   Valid,
  output logic                    Update,
  output logic [2:0]              UpdIdx,
  output logic                    CodeErr,
  output logic                    AnodeErr
);

  localparam int         SW  = NUM_DIGITS + 8;
  localparam logic [7:0] STB = 8'(STABLE_CYCLES);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACK = 2'd1,
    HOLD  = 2'd2
  } state_t;

  logic [7:0]            seg1_q, seg2_q;
  logic [NUM_DIGITS-1:0] an1_q, an2_q;

  state_t                state_q, state_d;
  logic [7:0]            cnt_q, cnt_d;
  logic [SW-1:0]         ref_q, ref_d;
  logic [2:0]            ridx_q, ridx_d;

  logic [SW-1:0]         samp;
  logic [3:0]            nz;
  logic [2:0]            sidx;
  logic                  legal, illegal, same, cap;
  logic [4:0]            dec;
  logic                  blank;

  logic [4*NUM_DIGITS-1:0] dig_q;
  logic [NUM_DIGITS-1:0]   dps_q, val_q;
  logic                    upd_q, cerr_q, aerr_q, ill_q;
  logic [2:0]              updidx_q;

  function automatic logic [4:0] dec7(input logic [6:0] g);
    logic [4:0] r;
    r = 5'h00;
    case (g)
      7'b0000001: r = 5'h10;
      7'b1001111: r = 5'h11;
      7'b0010010: r = 5'h12;
      7'b0000110: r = 5'h13;
      7'b1001100: r = 5'h14;
      7'b0100100: r = 5'h15;
      7'b0100000: r = 5'h16;
      7'b0001111: r = 5'h17;
      7'b0000000: r = 5'h18;
      7'b0000100: r = 5'h19;
      7'b0001000: r = 5'h1A;
      7'b1100000: r = 5'h1B;
      7'b0110001: r = 5'h1C;
      7'b1000010: r = 5'h1D;
      7'b0110000: r = 5'h1E;
      7'b0111000: r = 5'h1F;
      default:    r = 5'h00;
    endcase
    return r;
  endfunction

  // Reset to all-ones so the bus looks idle until real samples arrive
  always_ff @(posedge Clk) begin
    if (Reset) begin
      seg1_q <= '1;
      seg2_q <= '1;
      an1_q  <= '1;
      an2_q  <= '1;
    end else begin
      seg1_q <= SSeg;
      seg2_q <= seg1_q;
      an1_q  <= Anode;
      an2_q  <= an1_q;
    end
  end

  always_comb begin
    nz   = '0;
    sidx = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (!an2_q[i]) begin
        nz   = nz + 4'd1;
        sidx = 3'(i);
      end
    end
  end

  assign samp    = {an2_q, seg2_q};
  assign legal   = (nz == 4'd1);
  assign illegal = (nz > 4'd1);
  assign same    = (samp == ref_q);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ref_d   = ref_q;
    ridx_d  = ridx_q;
    cap     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (legal) begin
          state_d = TRACK;
          cnt_d   = 8'd1;
          ref_d   = samp;
          ridx_d  = sidx;
        end
      end
      TRACK, HOLD: begin
        cap = (state_q == TRACK) && (cnt_q == STB);
        if (legal && same) begin
          if (state_q == TRACK && !cap) cnt_d = cnt_q + 8'd1;
          else state_d = HOLD;
        end else if (legal) begin
          state_d = TRACK;
          cnt_d   = 8'd1;
          ref_d   = samp;
          ridx_d  = sidx;
        end else begin
          state_d = IDLE;
          cnt_d   = 8'd0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 8'd0;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ref_q   <= '1;
      ridx_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ref_q   <= ref_d;
      ridx_q  <= ridx_d;
    end
  end

  assign dec   = dec7(ref_q[7:1]);
  assign blank = (ref_q[7:1] == 7'h7F);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      dig_q    <= '0;
      dps_q    <= '0;
      val_q    <= '0;
      upd_q    <= 1'b0;
      cerr_q   <= 1'b0;
      aerr_q   <= 1'b0;
      ill_q    <= 1'b0;
      updidx_q <= '0;
    end else begin
      upd_q  <= cap;
      cerr_q <= cap && !dec[4] && !blank;
      aerr_q <= illegal && !ill_q;
      ill_q  <= illegal;
      if (cap) begin
        updidx_q <= ridx_q;
        for (int i = 0; i < NUM_DIGITS; i++) begin
          if (ridx_q == 3'(i)) begin
            if (dec[4]) begin
              dig_q[4*i +: 4] <= dec[3:0];
              dps_q[i]        <= ~ref_q[0];
              val_q[i]        <= 1'b1;
            end else begin
              val_q[i] <= 1'b0;
              if (blank) dps_q[i] <= ~ref_q[0];
            end
          end
        end
      end
    end
  end

  assign Digits   = dig_q;
  assign DPs      = dps_q;
  assign Valid    = val_q;
  assign Update   = upd_q;
  assign UpdIdx   = updidx_q;
  assign CodeErr  = cerr_q;
  assign AnodeErr = aerr_q;

endmodule

// File: tb/tb_sseg_anode_scan_capture.sv
// Bench for sseg_anode_scan_capture: directed scenarios with literal
// expectations plus a random scan against a run-length reference model.
module tb_sseg_anode_scan_capture;

  localparam int N   = 4;
  localparam int STB = 16;

  localparam logic [6:0] GLY [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  logic         Clk = 1'b0;
  logic         Reset = 1'b1;
  logic [7:0]   SSeg = 8'hFF;
  logic [N-1:0] Anode = '1;
  logic [4*N-1:0] Digits;
  logic [N-1:0] DPs, Valid;
  logic         Update, CodeErr, AnodeErr;
  logic [2:0]   UpdIdx;

  int vectors = 0;
  int errors  = 0;

  sseg_anode_scan_capture #(.NUM_DIGITS(N), .STABLE_CYCLES(STB)) dut (
    .Clk(Clk), .Reset(Reset), .SSeg(SSeg), .Anode(Anode),
    .Digits(Digits), .DPs(DPs), .Valid(Valid), .Update(Update),
    .UpdIdx(UpdIdx), .CodeErr(CodeErr), .AnodeErr(AnodeErr)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string nm, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  // -1 illegal glyph, 16 blank, else hex value
  function automatic int mdec(input logic [6:0] g);
    for (int h = 0; h < 16; h++) if (g == GLY[h]) return h;
    if (g == 7'h7F) return 16;
    return -1;
  endfunction

  // Reference model: S seen by the tracker is the pin value two edges old;
  // a capture fires on the edge after a run of STB equal legal samples
  logic [N+7:0]   p1, p2, m_last, m_cval;
  int             m_len, m_cidx;
  bit             m_done, m_pend, m_prev_ill, m_on = 0;
  logic [4*N-1:0] e_dig;
  logic [N-1:0]   e_dp, e_val;
  bit             e_upd, e_cerr, e_aerr;
  int             e_idx;

  always @(posedge Clk) begin
    logic [N+7:0] s;
    int nzero, oidx, d;
    if (Reset) begin
      m_on = 1; p1 = '1; p2 = '1; m_last = '1;
      m_len = 0; m_done = 0; m_pend = 0; m_prev_ill = 0;
      e_dig = '0; e_dp = '0; e_val = '0;
      e_upd = 0; e_cerr = 0; e_aerr = 0; e_idx = 0;
    end else begin
      s = p2; p2 = p1; p1 = {Anode, SSeg};
      e_upd = 0; e_cerr = 0;
      if (m_pend) begin
        m_pend = 0; e_upd = 1; e_idx = m_cidx;
        d = mdec(m_cval[7:1]);
        if (d >= 0 && d < 16) begin
          e_dig[4*m_cidx +: 4] = 4'(d);
          e_dp[m_cidx] = ~m_cval[0];
          e_val[m_cidx] = 1'b1;
        end else if (d == 16) begin
          e_val[m_cidx] = 1'b0;
          e_dp[m_cidx] = ~m_cval[0];
        end else begin
          e_val[m_cidx] = 1'b0;
          e_cerr = 1;
        end
      end
      nzero = 0; oidx = 0;
      for (int i = 0; i < N; i++) if (!s[8+i]) begin nzero++; oidx = i; end
      e_aerr = (nzero > 1) && !m_prev_ill;
      m_prev_ill = (nzero > 1);
      if (nzero == 1) begin
        if (m_len > 0 && s == m_last) m_len++;
        else begin m_len = 1; m_done = 0; end
      end else begin
        m_len = 0; m_done = 0;
      end
      m_last = s;
      if (m_len == STB && !m_done) begin
        m_pend = 1; m_done = 1; m_cval = s; m_cidx = oidx;
      end
    end
  end

  always @(negedge Clk) begin
    if (m_on) begin
      chk("Digits", int'(Digits), int'(e_dig));
      chk("DPs", int'(DPs), int'(e_dp));
      chk("Valid", int'(Valid), int'(e_val));
      chk("Update", int'(Update), int'(e_upd));
      chk("CodeErr", int'(CodeErr), int'(e_cerr));
      chk("AnodeErr", int'(AnodeErr), int'(e_aerr));
      if (e_upd) chk("UpdIdx", int'(UpdIdx), e_idx);
    end
  end

  // Called at a negedge; the following posedge is edge 0 of the hold
  task automatic hold(input logic [N-1:0] an, input logic [7:0] sg,
                      input int n, output int nupd, output int fupd,
                      output int ncerr, output int naerr, output int faerr,
                      output int lidx);
    nupd = 0; fupd = -1; ncerr = 0; naerr = 0; faerr = -1; lidx = -1;
    Anode = an; SSeg = sg;
    for (int i = 0; i < n; i++) begin
      @(posedge Clk); #1;
      if (Update) begin
        nupd++; lidx = int'(UpdIdx);
        if (fupd < 0) fupd = i;
      end
      if (CodeErr) ncerr++;
      if (AnodeErr) begin
        naerr++;
        if (faerr < 0) faerr = i;
      end
    end
    @(negedge Clk);
  endtask

  initial begin
    int nu, fu, nc, na, fa, li, tot;
    logic [N-1:0] an;
    logic [7:0] sg;
    int r, g, dw;

    repeat (3) @(posedge Clk);
    #1;
    chk("rst_Digits", int'(Digits), 0);
    chk("rst_Valid", int'(Valid), 0);
    chk("rst_Update", int'(Update), 0);
    @(negedge Clk);
    Reset = 1'b0;

    // reset in the middle of tracking a digit
    hold(4'b1110, 8'b0000110_0, 7, nu, fu, nc, na, fa, li);
    chk("mid_noupd", nu, 0);
    Reset = 1'b1;
    @(posedge Clk); #1;
    chk("mid_rst_Digits", int'(Digits), 0);
    chk("mid_rst_Valid", int'(Valid), 0);
    chk("mid_rst_DPs", int'(DPs), 0);
    chk("mid_rst_Update", int'(Update), 0);
    @(negedge Clk);
    Reset = 1'b0;

    // digit 0 shows "3." : one capture exactly 18 edges in
    hold(4'b1110, 8'b0000110_0, 20, nu, fu, nc, na, fa, li);
    chk("d3_nupd", nu, 1);
    chk("d3_when", fu, 18);
    chk("d3_idx", li, 0);
    chk("d3_digit", int'(Digits[3:0]), 3);
    chk("d3_dp", int'(DPs[0]), 1);
    chk("d3_valid", int'(Valid[0]), 1);

    // scan 1 8 F A twice
    tot = 0;
    for (int rep = 0; rep < 2; rep++) begin
      hold(4'b1110, {GLY[1], 1'b1}, 32, nu, fu, nc, na, fa, li); tot += nu;
      hold(4'b1101, {GLY[8], 1'b1}, 32, nu, fu, nc, na, fa, li); tot += nu;
      hold(4'b1011, {GLY[15], 1'b1}, 32, nu, fu, nc, na, fa, li); tot += nu;
      hold(4'b0111, {GLY[10], 1'b1}, 32, nu, fu, nc, na, fa, li); tot += nu;
    end
    chk("scan_nupd", tot, 8);
    chk("scan_Digits", int'(Digits), 16'hAF81);
    chk("scan_Valid", int'(Valid), 4'hF);
    chk("scan_DPs", int'(DPs), 0);

    // flicker shorter than the stability window
    tot = 0;
    for (int k = 0; k < 8; k++) begin
      hold(4'b1011, {(k % 2 == 0) ? 7'h00 : 7'h4F, 1'b1}, 8,
           nu, fu, nc, na, fa, li);
      tot += nu;
    end
    chk("flick_nupd", tot, 0);
    chk("flick_digit2", int'(Digits[11:8]), 4'hF);

    // bad glyph, then blank with DP
    hold(4'b1101, 8'b1010101_1, 20, nu, fu, nc, na, fa, li);
    chk("bad_nupd", nu, 1);
    chk("bad_cerr", nc, 1);
    chk("bad_valid1", int'(Valid[1]), 0);
    chk("bad_digit1", int'(Digits[7:4]), 8);
    hold(4'b1101, 8'b1111111_0, 20, nu, fu, nc, na, fa, li);
    chk("blk_nupd", nu, 1);
    chk("blk_cerr", nc, 0);
    chk("blk_valid1", int'(Valid[1]), 0);
    chk("blk_dp1", int'(DPs[1]), 1);

    // two anodes active, then a legal digit 3
    hold(4'b0011, 8'b0000001_1, 10, nu, fu, nc, na, fa, li);
    chk("ae_count", na, 1);
    chk("ae_when", fa, 2);
    chk("ae_nupd", nu, 0);
    hold(4'b0111, {GLY[5], 1'b1}, 20, nu, fu, nc, na, fa, li);
    chk("ae_rec_nupd", nu, 1);
    chk("ae_rec_idx", li, 3);
    chk("ae_rec_digit3", int'(Digits[15:12]), 5);

    // random scan, checked cycle by cycle against the model
    for (int seg = 0; seg < 160; seg++) begin
      r = $urandom_range(0, 9);
      an = '1;
      if (r == 6) an = '1;
      else if (r == 7) begin
        an[$urandom_range(0, 1)] = 1'b0;
        an[$urandom_range(2, 3)] = 1'b0;
      end else an[$urandom_range(0, N-1)] = 1'b0;
      g = $urandom_range(0, 13);
      if (g < 12) sg[7:1] = GLY[$urandom_range(0, 15)];
      else if (g == 12) sg[7:1] = 7'h7F;
      else sg[7:1] = 7'($urandom);
      sg[0] = 1'($urandom);
      dw = $urandom_range(1, 40);
      Anode = an; SSeg = sg;
      repeat (dw) @(negedge Clk);
      if ($urandom_range(0, 24) == 0) begin
        Reset = 1'b1;
        repeat ($urandom_range(1, 2)) @(negedge Clk);
        Reset = 1'b0;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
